// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared defaults, lane-count derivation and output-stage state
//               encoding for the matrix register file.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

    // One entry holds a 4x4 matrix of 16-bit elements
    localparam int DATA_W_DEF = 256;
    localparam int ELEM_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int LANES_DEF  = DATA_W_DEF / ELEM_W_DEF;

    // Number of independently maskable lanes in one entry
    function automatic int lanes_of(input int data_w, input int elem_w);
        return data_w / elem_w;
    endfunction

    // Output register stage: EMPTY holds nothing, FULL presents rdData
    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage
`default_nettype wire

// File: rtl/mm_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : mm_lane_merge
// Description : Combinational per-lane merge; lanes with mask set take the
//               new data, the rest keep the old data.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_lane_merge
    import mm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ELEM_W = ELEM_W_DEF,
    localparam int LANES = lanes_of(DATA_W, ELEM_W)
) (
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] new_i,
    input  logic [LANES-1:0]  mask_i,
    output logic [DATA_W-1:0] merged_o
);

    // Lane-by-lane select between retained and incoming element
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign merged_o[g*ELEM_W +: ELEM_W] = mask_i[g] ? new_i[g*ELEM_W +: ELEM_W]
                                                        : old_i[g*ELEM_W +: ELEM_W];
    end

endmodule
`default_nettype wire

// File: rtl/matrix_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : matrix_reg_file
// Description : Lane-masked register file of matrix entries with per-entry
//               valid bits, optional write-to-read bypass and a registered
//               valid/ready read output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_reg_file
    import mm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int BYPASS = 1,
    localparam int LANES  = lanes_of(DATA_W, ELEM_W),
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clrAll,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [LANES-1:0]  wrMask,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdReq,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdAck,
    output logic              rdValid,
    input  logic              rdReady,
    output logic [DATA_W-1:0] rdData,
    output logic              rdErr
);

    // One extra bit so DEPTH itself is representable for the range checks
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    logic              wr_in_range;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_merged;
    logic              rd_in_range;
    logic [ADDR_W-1:0] rd_idx;
    logic              wr_hits_rd;
    logic [DATA_W-1:0] lookup_data;
    logic              lookup_err;

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_err_q, rd_err_d;

    // Out-of-range addresses are steered to entry 0 so indexing stays legal;
    // the range flags keep them from having any effect.
    assign wr_in_range = ({1'b0, wrAddr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rdAddr} < DEPTH_L);
    assign wr_idx      = wr_in_range ? wrAddr : '0;
    assign rd_idx      = rd_in_range ? rdAddr : '0;
    assign wr_hits_rd  = wrEn && wr_in_range && (wrAddr == rdAddr);

    // The merged value is both what gets stored and what a bypassed read sees
    mm_lane_merge #(
        .DATA_W (DATA_W),
        .ELEM_W (ELEM_W)
    ) u_merge (
        .old_i    (mem_q[wr_idx]),
        .new_i    (wrData),
        .mask_i   (wrMask),
        .merged_o (wr_merged)
    );

    // Entry storage: reset and clear-all wipe everything and beat any write
    always_ff @(posedge clk) begin
        if (reset || clrAll) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (wrEn && wr_in_range) begin
            mem_q[wr_idx]   <= wr_merged;
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Read lookup: clear-all wins, then bypass, then stored contents
    always_comb begin
        lookup_data = '0;
        lookup_err  = 1'b1;
        if (clrAll) begin
            lookup_data = '0;
            lookup_err  = 1'b1;
        end else if ((BYPASS != 0) && wr_hits_rd) begin
            lookup_data = wr_merged;
            lookup_err  = 1'b0;
        end else if (rd_in_range && valid_q[rd_idx]) begin
            lookup_data = mem_q[rd_idx];
            lookup_err  = 1'b0;
        end
    end

    // Output stage next-state: accept when empty or when the held word leaves
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        rdAck     = rdReq && !reset && ((state_q == OUT_EMPTY) || rdReady);
        if (rdAck) begin
            state_d   = OUT_FULL;
            rd_data_d = lookup_data;
            rd_err_d  = lookup_err;
        end else if ((state_q == OUT_FULL) && rdReady) begin
            state_d = OUT_EMPTY;
        end
    end

    // Output stage registers; reset discards any held word immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OUT_EMPTY;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign rdValid = (state_q == OUT_FULL);
    assign rdData  = rd_data_q;
    assign rdErr   = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_reg_file
// Description : Directed bench for matrix_reg_file. Three instances share one
//               stimulus: default (BYPASS=1), BYPASS=0, and DEPTH=6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_reg_file;

    localparam int DW = 256;
    localparam int LN = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          clrAll;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [LN-1:0] wrMask;
    logic [DW-1:0] wrData;
    logic          rdReq;
    logic [AW-1:0] rdAddr;
    logic          rdReady;

    logic          ack_b1, vld_b1, err_b1;
    logic [DW-1:0] data_b1;
    logic          ack_b0, vld_b0, err_b0;
    logic [DW-1:0] data_b0;
    logic          ack_d6, vld_d6, err_d6;
    logic [DW-1:0] data_d6;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    matrix_reg_file #(.DATA_W(DW), .ELEM_W(16), .DEPTH(8), .BYPASS(1)) dut_b1 (
        .clk(clk), .reset(reset), .clrAll(clrAll), .wrEn(wrEn), .wrAddr(wrAddr),
        .wrMask(wrMask), .wrData(wrData), .rdReq(rdReq), .rdAddr(rdAddr),
        .rdAck(ack_b1), .rdValid(vld_b1), .rdReady(rdReady), .rdData(data_b1), .rdErr(err_b1));

    matrix_reg_file #(.DATA_W(DW), .ELEM_W(16), .DEPTH(8), .BYPASS(0)) dut_b0 (
        .clk(clk), .reset(reset), .clrAll(clrAll), .wrEn(wrEn), .wrAddr(wrAddr),
        .wrMask(wrMask), .wrData(wrData), .rdReq(rdReq), .rdAddr(rdAddr),
        .rdAck(ack_b0), .rdValid(vld_b0), .rdReady(rdReady), .rdData(data_b0), .rdErr(err_b0));

    matrix_reg_file #(.DATA_W(DW), .ELEM_W(16), .DEPTH(6), .BYPASS(1)) dut_d6 (
        .clk(clk), .reset(reset), .clrAll(clrAll), .wrEn(wrEn), .wrAddr(wrAddr),
        .wrMask(wrMask), .wrData(wrData), .rdReq(rdReq), .rdAddr(rdAddr),
        .rdAck(ack_d6), .rdValid(vld_d6), .rdReady(rdReady), .rdData(data_d6), .rdErr(err_d6));

    typedef struct {
        logic          clr;
        logic          we;
        logic [AW-1:0] wa;
        logic [LN-1:0] wm;
        logic [DW-1:0] wd;
        logic          rq;
        logic [AW-1:0] ra;
        logic          rr;
        logic          ack;
        logic          cd;
        logic          vld;
        logic [DW-1:0] d1;
        logic          e1;
        logic [DW-1:0] d0;
        logic          e0;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    localparam logic [DW-1:0] Z   = '0;
    localparam logic [DW-1:0] V2  = {2{128'h00112233445566778899AABBCCDDEEFF}};
    localparam logic [DW-1:0] VA  = {16{16'hAAAA}};
    localparam logic [DW-1:0] V5  = {16{16'h5555}};
    localparam logic [DW-1:0] MRG = {{15{16'hAAAA}}, 16'h5555};
    localparam logic [DW-1:0] BW  = {{15{16'hFFFF}}, 16'h1234};
    localparam logic [DW-1:0] BR  = {240'd0, 16'h1234};
    localparam logic [DW-1:0] OLD = {16{16'h0F0F}};
    localparam logic [DW-1:0] BN  = {{15{16'h0F0F}}, 16'h1234};
    localparam logic [DW-1:0] X4  = {16{16'h4444}};
    localparam logic [DW-1:0] X6  = {16{16'h6666}};
    localparam logic [DW-1:0] X7  = {16{16'h7777}};

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic we, input logic [AW-1:0] wa,
                         input logic [LN-1:0] wm, input logic [DW-1:0] wd,
                         input logic rq, input logic [AW-1:0] ra, input logic rr);
        clrAll  = clr;
        wrEn    = we;
        wrAddr  = wa;
        wrMask  = wm;
        wrData  = wd;
        rdReq   = rq;
        rdAddr  = ra;
        rdReady = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] got [$];

    initial begin
        // clr we wa wm wd rq ra rr | ack cd vld d1 e1 d0 e0
        vt[0]  = '{1'b0, 1'b1, 3'd2, 16'hFFFF, V2,  1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, Z,   1'b0, Z,   1'b0};
        vt[1]  = '{1'b0, 1'b0, 3'd0, 16'h0000, Z,   1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, V2,  1'b0, V2,  1'b0};
        vt[2]  = '{1'b0, 1'b1, 3'd1, 16'hFFFF, VA,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, Z,   1'b0, Z,   1'b0};
        vt[3]  = '{1'b0, 1'b1, 3'd1, 16'h0001, V5,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, Z,   1'b0, Z,   1'b0};
        vt[4]  = '{1'b0, 1'b0, 3'd0, 16'h0000, Z,   1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, MRG, 1'b0, MRG, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 3'd0, 16'h0000, Z,   1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, Z,   1'b1, Z,   1'b1};
        vt[6]  = '{1'b0, 1'b1, 3'd3, 16'h0001, BW,  1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, BR,  1'b0, Z,   1'b1};
        vt[7]  = '{1'b0, 1'b0, 3'd0, 16'h0000, Z,   1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, BR,  1'b0, BR,  1'b0};
        vt[8]  = '{1'b1, 1'b1, 3'd0, 16'hFFFF, V2,  1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, Z,   1'b1, Z,   1'b1};
        vt[9]  = '{1'b0, 1'b0, 3'd0, 16'h0000, Z,   1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, Z,   1'b1, Z,   1'b1};
        vt[10] = '{1'b0, 1'b0, 3'd0, 16'h0000, Z,   1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, Z,   1'b0, Z,   1'b0};

        // Reset with a pending request: request must be refused
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 16'h0, Z, 1'b1, 3'd2, 1'b1);
        #1;
        chk("reset ack", {255'd0, ack_b1}, Z);
        tick();
        tick();
        chk("reset vld", {255'd0, vld_b1}, Z);
        chk("reset data", data_b1, Z);
        chk("reset err", {255'd0, err_b1}, Z);
        reset = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].clr, vt[i].we, vt[i].wa, vt[i].wm, vt[i].wd, vt[i].rq, vt[i].ra, vt[i].rr);
            #1;
            chk($sformatf("v%0d ack_b1", i), {255'd0, ack_b1}, {255'd0, vt[i].ack});
            chk($sformatf("v%0d ack_b0", i), {255'd0, ack_b0}, {255'd0, vt[i].ack});
            tick();
            chk($sformatf("v%0d vld_b1", i), {255'd0, vld_b1}, {255'd0, vt[i].vld});
            chk($sformatf("v%0d vld_b0", i), {255'd0, vld_b0}, {255'd0, vt[i].vld});
            if (vt[i].cd) begin
                chk($sformatf("v%0d data_b1", i), data_b1, vt[i].d1);
                chk($sformatf("v%0d err_b1", i), {255'd0, err_b1}, {255'd0, vt[i].e1});
                chk($sformatf("v%0d data_b0", i), data_b0, vt[i].d0);
                chk($sformatf("v%0d err_b0", i), {255'd0, err_b0}, {255'd0, vt[i].e0});
            end
        end

        // Backpressure: three reads, consumer stalls for three cycles
        drive(1'b0, 1'b1, 3'd4, 16'hFFFF, X4, 1'b0, 3'd0, 1'b1); tick();
        drive(1'b0, 1'b1, 3'd6, 16'hFFFF, X6, 1'b0, 3'd0, 1'b1); tick();
        drive(1'b0, 1'b1, 3'd7, 16'hFFFF, X7, 1'b0, 3'd0, 1'b1); tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0, Z, 1'b1, 3'd4, 1'b0);
        #1;
        chk("bp first ack", {255'd0, ack_b1}, {255'd0, 1'b1});
        tick();
        chk("d6 addr4 data", data_d6, X4);
        chk("d6 addr4 err", {255'd0, err_d6}, Z);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 3'd0, 16'h0, Z, 1'b1, 3'd6, 1'b0);
            #1;
            chk($sformatf("bp stall%0d ack", c), {255'd0, ack_b1}, Z);
            tick();
            chk($sformatf("bp stall%0d vld", c), {255'd0, vld_b1}, {255'd0, 1'b1});
            chk($sformatf("bp stall%0d data", c), data_b1, X4);
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0, Z, 1'b1, 3'd6, 1'b1);
        #1;
        if (vld_b1 && rdReady) got.push_back(data_b1);
        tick();
        chk("d6 addr6 data", data_d6, Z);
        chk("d6 addr6 err", {255'd0, err_d6}, {255'd0, 1'b1});
        drive(1'b0, 1'b0, 3'd0, 16'h0, Z, 1'b1, 3'd7, 1'b1);
        #1;
        if (vld_b1 && rdReady) got.push_back(data_b1);
        tick();
        chk("d6 addr7 data", data_d6, Z);
        chk("d6 addr7 err", {255'd0, err_d6}, {255'd0, 1'b1});
        drive(1'b0, 1'b0, 3'd0, 16'h0, Z, 1'b0, 3'd0, 1'b1);
        #1;
        if (vld_b1 && rdReady) got.push_back(data_b1);
        tick();
        chk("bp drain vld", {255'd0, vld_b1}, Z);
        chk("bp count", 256'(got.size()), 256'd3);
        if (got.size() == 3) begin
            chk("bp item0", got[0], X4);
            chk("bp item1", got[1], X6);
            chk("bp item2", got[2], X7);
        end

        // Bypass versus old-data on a partially masked overwrite
        drive(1'b0, 1'b1, 3'd3, 16'hFFFF, OLD, 1'b0, 3'd0, 1'b1); tick();
        drive(1'b0, 1'b1, 3'd3, 16'h0001, BW, 1'b1, 3'd3, 1'b1); tick();
        chk("byp1 data", data_b1, BN);
        chk("byp1 err", {255'd0, err_b1}, Z);
        chk("byp0 data", data_b0, OLD);
        chk("byp0 err", {255'd0, err_b0}, Z);

        // Empty mask still marks the entry as written
        drive(1'b0, 1'b1, 3'd5, 16'h0000, BW, 1'b0, 3'd0, 1'b1); tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0, Z, 1'b1, 3'd5, 1'b1); tick();
        chk("mask0 data", data_b1, Z);
        chk("mask0 err", {255'd0, err_b1}, Z);

        // Held output survives clear-all; reset then discards it
        drive(1'b0, 1'b0, 3'd0, 16'h0, Z, 1'b1, 3'd3, 1'b1); tick();
        drive(1'b1, 1'b0, 3'd0, 16'h0, Z, 1'b0, 3'd0, 1'b0); tick();
        chk("clr hold vld", {255'd0, vld_b1}, {255'd0, 1'b1});
        chk("clr hold data", data_b1, BN);
        drive(1'b0, 1'b1, 3'd2, 16'hFFFF, X4, 1'b0, 3'd0, 1'b0); tick();
        chk("clr hold data2", data_b1, BN);
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 16'h0, Z, 1'b1, 3'd2, 1'b1);
        #1;
        chk("rst full ack", {255'd0, ack_b1}, Z);
        tick();
        reset = 1'b0;
        chk("rst full vld", {255'd0, vld_b1}, Z);
        chk("rst full data", data_b1, Z);
        drive(1'b0, 1'b0, 3'd0, 16'h0, Z, 1'b1, 3'd2, 1'b1); tick();
        chk("post rst data", data_b1, Z);
        chk("post rst err", {255'd0, err_b1}, {255'd0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
